// File: rtl/shift_seq_arb_4b.sv
// ---------------------------------------------------------------------------
// shift_seq_arb_4b
//   Round-robin arbiter and sequencer for the 4-bit shift datapath. Two
//   requesters submit (operand, direction, amount) jobs. The granted job is
//   shifted one bit per clock in an internal register. The result is then
//   returned on dout with a one-cycle done pulse to the owning requester.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active high
//   req_a/req_b    job request levels
//   dir_a/dir_b    0 = logical right, 1 = logical left
//   amt_a/amt_b    shift amount (clamped to WIDTH)
//   din_a/din_b    operand
//   gnt_a/gnt_b    one-cycle pulse, job accepted
//   done_a/done_b  one-cycle pulse, result valid on dout
//   dout           result of last completed job (held between jobs)
//   busy           high in SHIFT and DONE
//   owner          0 = A, 1 = B; current or last granted requester
// ---------------------------------------------------------------------------
module shift_seq_arb_4b #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             dir_a,
   input  logic [AMT_W-1:0] amt_a,
   input  logic [WIDTH-1:0] din_a,
   input  logic             req_b,
   input  logic             dir_b,
   input  logic [AMT_W-1:0] amt_b,
   input  logic [WIDTH-1:0] din_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             owner
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;

   logic [WIDTH-1:0]   r_sreg;
   logic [AMT_W-1:0]   r_cnt;
   logic               r_dir;
   logic               r_owner;
   logic               r_last_b;   // 1 = B was served last, so A wins a tie
   logic [WIDTH-1:0]   r_dout;
   logic               r_gnt_a;
   logic               r_gnt_b;
   logic               r_done_a;
   logic               r_done_b;

   logic               w_req;
   logic               w_pick_b;
   logic [AMT_W-1:0]   w_amt;
   logic [AMT_W-1:0]   w_amt_clamp;

   assign w_req       = req_a | req_b;
   // B wins when alone, or when both request and A was served last.
   assign w_pick_b    = req_b & (~req_a | ~r_last_b);
   assign w_amt       = w_pick_b ? amt_b : amt_a;
   assign w_amt_clamp = (w_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : w_amt;

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req) w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // datapath and registered pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sreg   <= '0;
         r_cnt    <= '0;
         r_dir    <= 1'b0;
         r_owner  <= 1'b0;
         r_last_b <= 1'b1;
         r_dout   <= '0;
         r_gnt_a  <= 1'b0;
         r_gnt_b  <= 1'b0;
         r_done_a <= 1'b0;
         r_done_b <= 1'b0;
      end else begin
         r_gnt_a  <= 1'b0;
         r_gnt_b  <= 1'b0;
         r_done_a <= 1'b0;
         r_done_b <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_owner <= w_pick_b;
                  r_gnt_a <= ~w_pick_b;
                  r_gnt_b <= w_pick_b;
                  r_sreg  <= w_pick_b ? din_b : din_a;
                  r_dir   <= w_pick_b ? dir_b : dir_a;
                  r_cnt   <= w_amt_clamp;
               end
            end
            S_SHIFT: begin
               if (r_cnt != '0) begin
                  r_sreg <= r_dir ? {r_sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_sreg[WIDTH-1:1]};
                  r_cnt  <= r_cnt - 1'b1;
               end else begin
                  r_dout   <= r_sreg;
                  r_done_a <= ~r_owner;
                  r_done_b <= r_owner;
               end
            end
            S_DONE:  r_last_b <= r_owner;
            default: ;
         endcase
      end
   end

   assign gnt_a  = r_gnt_a;
   assign gnt_b  = r_gnt_b;
   assign done_a = r_done_a;
   assign done_b = r_done_b;
   assign dout   = r_dout;
   assign busy   = (r_state != S_IDLE);
   assign owner  = r_owner;

endmodule
